// File: rtl/sram_responder.sv
// Behavioural single-port SRAM (CENA/WENA/AA/DA/QA) with power-up clear sweep and optional access counters.
// Latency: read data/rvalid READ_LAT edges after the sample edge (1..4); addr_err and counters one cycle after.
// Backpressure: none; one access per cycle is accepted once ready=1, accesses during the clear sweep are ignored.
// Optional feature: define SRAM_RESPONDER_ACCESS_CNT_EN to enable the saturating rd_cnt/wr_cnt counters.
module sram_responder #(
    parameter int WORD_BIT = 32,
    parameter int ADDR_BIT = 8,
    parameter int DEPTH    = 1 << ADDR_BIT,
    parameter int READ_LAT = 1,
    parameter int CNT_BIT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen_n,
    input  logic                wen_n,
    input  logic [ADDR_BIT-1:0] addr,
    input  logic [WORD_BIT-1:0] wdata,
    output logic [WORD_BIT-1:0] rdata,
    output logic                rvalid,
    output logic                ready,
    output logic                addr_err,
    output logic [CNT_BIT-1:0]  rd_cnt,
    output logic [CNT_BIT-1:0]  wr_cnt
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(DEPTH - 1);
    localparam logic [ADDR_BIT:0]   DEPTH_W   = (ADDR_BIT + 1)'(DEPTH);

    state_t                state;
    logic [ADDR_BIT-1:0]   clr_ptr;
    logic [WORD_BIT-1:0]   mem [DEPTH];

    logic                  acc;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  in_range;
    logic [WORD_BIT-1:0]   rd_word;
    logic                  dlv_v;
    logic [WORD_BIT-1:0]   dlv_d;

    // Decode the host access; only honoured once the sweep has finished.
    always_comb begin
        acc      = (state == READY) && !cen_n;
        rd_fire  = acc && wen_n;
        wr_fire  = acc && !wen_n;
        in_range = ({1'b0, addr} < DEPTH_W);
        rd_word  = in_range ? mem[addr] : '0;
    end

    // Clear-sweep FSM: one word zeroed per edge, then READY until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_BIT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Array write port shared by the sweep and host writes; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_fire && in_range) begin
            mem[addr] <= wdata;
        end
    end

    // Read pipeline: the sample edge captures the word, the output register is the last of READ_LAT stages.
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign dlv_v = rd_fire;
            assign dlv_d = rd_word;
        end else begin : g_latn
            logic [READ_LAT-2:0] pv;
            logic [WORD_BIT-1:0] pd [READ_LAT-1];

            // Valid bits are flushed by reset so in-flight reads never complete.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_fire;
                    for (int i = 1; i < READ_LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            // Data stages carry no reset; they are qualified by the valid bits.
            always_ff @(posedge clk) begin
                pd[0] <= rd_word;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            assign dlv_v = pv[READ_LAT-2];
            assign dlv_d = pd[READ_LAT-2];
        end
    endgenerate

    // Output register: rdata holds its last value between reads; addr_err is one cycle after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= dlv_v;
            addr_err <= acc && !in_range;
            if (dlv_v) begin
                rdata <= dlv_d;
            end
        end
    end

`ifdef SRAM_RESPONDER_ACCESS_CNT_EN
    // Saturating counters of honoured accesses, out-of-range ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_fire && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_BIT'(1);
            end
            if (wr_fire && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_BIT'(1);
            end
        end
    end
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (READ_LAT 1/3/2, CNT_BIT 16/16/3) share one stimulus stream.
// A transaction-level model predicts every output each cycle; directed checks pin literal values.
module tb_sram_responder;

    localparam int DEPTH = 200;
`ifdef SRAM_RESPONDER_ACCESS_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen_n = 1'b1;
    logic        wen_n = 1'b1;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        ready_a, ready_b, ready_c;
    logic        err_a, err_b, err_c;
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
    logic [2:0]  rdc_c, wrc_c;

    always #5 clk = ~clk;

    sram_responder #(.WORD_BIT(32), .ADDR_BIT(8), .DEPTH(DEPTH), .READ_LAT(1), .CNT_BIT(16)) u_a (
        .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
        .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a), .addr_err(err_a),
        .rd_cnt(rdc_a), .wr_cnt(wrc_a));
    sram_responder #(.WORD_BIT(32), .ADDR_BIT(8), .DEPTH(DEPTH), .READ_LAT(3), .CNT_BIT(16)) u_b (
        .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b), .addr_err(err_b),
        .rd_cnt(rdc_b), .wr_cnt(wrc_b));
    sram_responder #(.WORD_BIT(32), .ADDR_BIT(8), .DEPTH(DEPTH), .READ_LAT(2), .CNT_BIT(3)) u_c (
        .clk(clk), .rst(rst), .cen_n(cen_n), .wen_n(wen_n), .addr(addr), .wdata(wdata),
        .rdata(rdata_c), .rvalid(rvalid_c), .ready(ready_c), .addr_err(err_c),
        .rd_cnt(rdc_c), .wr_cnt(wrc_c));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m [DEPTH];
    int          clr_cnt;
    bit          ready_m;
    bit          started = 1'b0;
    bit          hv [4];
    logic [31:0] hd [4];
    bit          e_rv [3];
    logic [31:0] e_rd [3];
    bit          e_err;
    int          cnt_rd, cnt_wr;
    int          lat [3] = '{1, 3, 2};

    function automatic logic [63:0] cexp(input int c, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        if (!CNT_ON) return 64'd0;
        return (longint'(c) > mx) ? 64'(mx) : 64'(c);
    endfunction

    // Model: reads see the array as of the sample edge and appear lat edges later.
    always @(posedge clk) begin
        bit hon, rd, wr, inr;
        if (rst) begin
            started = 1'b1;
            clr_cnt = 0;
            ready_m = 1'b0;
            e_err   = 1'b0;
            cnt_rd  = 0;
            cnt_wr  = 0;
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
            for (int i = 0; i < 4; i++) begin hv[i] = 1'b0; hd[i] = '0; end
            for (int k = 0; k < 3; k++) begin e_rv[k] = 1'b0; e_rd[k] = '0; end
        end else begin
            hon = ready_m && (cen_n == 1'b0);
            rd  = hon && wen_n;
            wr  = hon && !wen_n;
            inr = (int'(addr) < DEPTH);
            for (int i = 3; i > 0; i--) begin hv[i] = hv[i-1]; hd[i] = hd[i-1]; end
            hv[0] = rd;
            hd[0] = inr ? m[addr] : 32'h0;
            if (wr && inr) m[addr] = wdata;
            e_err = hon && !inr;
            for (int k = 0; k < 3; k++) begin
                e_rv[k] = hv[lat[k]-1];
                if (e_rv[k]) e_rd[k] = hd[lat[k]-1];
            end
            if (rd) cnt_rd++;
            if (wr) cnt_wr++;
            if (!ready_m) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) ready_m = 1'b1;
            end
        end
    end

    // Compare every cycle, after the model and the DUT have settled.
    always @(posedge clk) begin
        #2;
        if (started) begin
            chk("a_rvalid", rvalid_a, e_rv[0]);
            chk("a_rdata",  rdata_a,  e_rd[0]);
            chk("a_ready",  ready_a,  ready_m);
            chk("a_err",    err_a,    e_err);
            chk("a_rdcnt",  rdc_a,    cexp(cnt_rd, 16));
            chk("a_wrcnt",  wrc_a,    cexp(cnt_wr, 16));
            chk("b_rvalid", rvalid_b, e_rv[1]);
            chk("b_rdata",  rdata_b,  e_rd[1]);
            chk("b_ready",  ready_b,  ready_m);
            chk("b_err",    err_b,    e_err);
            chk("b_rdcnt",  rdc_b,    cexp(cnt_rd, 16));
            chk("c_rvalid", rvalid_c, e_rv[2]);
            chk("c_rdata",  rdata_c,  e_rd[2]);
            chk("c_ready",  ready_c,  ready_m);
            chk("c_err",    err_c,    e_err);
            chk("c_rdcnt",  rdc_c,    cexp(cnt_rd, 3));
            chk("c_wrcnt",  wrc_c,    cexp(cnt_wr, 3));
        end
    end

    int rva = 0, rvb = 0;
    always @(negedge clk) begin
        if (rvalid_a === 1'b1) rva++;
        if (rvalid_b === 1'b1) rvb++;
    end

    // ---------------- stimulus ----------------
    task automatic acc(input bit w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cen_n = 1'b0;
        wen_n = w ? 1'b0 : 1'b1;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cen_n = 1'b1;
            wen_n = 1'b1;
        end
    endtask

    // Counts edges until ready rises; optionally injects a write sampled on the third edge.
    task automatic wait_ready(input bit inject, output int n);
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (inject && n == 2) begin
                cen_n = 1'b0; wen_n = 1'b0; addr = 8'h20; wdata = 32'hAAAA5555;
            end else begin
                cen_n = 1'b1; wen_n = 1'b1;
            end
            if (ready_a === 1'b1) break;
        end
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp);
        bit ga, gb;
        ga = 1'b0;
        gb = 1'b0;
        acc(1'b0, a, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cen_n = 1'b1;
            if (rvalid_a === 1'b1 && !ga) begin
                ga = 1'b1;
                chk("rd_lat_a", k, 1);
                chk("rd_dat_a", rdata_a, exp);
            end
            if (rvalid_b === 1'b1 && !gb) begin
                gb = 1'b1;
                chk("rd_lat_b", k, 3);
                chk("rd_dat_b", rdata_b, exp);
            end
        end
        chk("rd_seen_a", ga, 1);
        chk("rd_seen_b", gb, 1);
    endtask

    initial begin
        int n, sa, sb;
        #1 rst = 1'b1;
        #3;
        chk("rst_ready",  ready_a,  0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_rdata",  rdata_a,  0);
        chk("rst_err",    err_a,    0);
        chk("rst_rdcnt",  rdc_a,    0);
        chk("rst_wrcnt",  wrc_a,    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clear sweep with a write attempted during it.
        wait_ready(1'b1, n);
        chk("clear_cycles", n, 200);
        chk("clear_ready_b", ready_b, 1);
        rd_chk(8'h05, 32'h0);
        rd_chk(8'h20, 32'h0);

        // Write followed immediately by a read of the same word.
        acc(1'b1, 8'h10, 32'hDEADBEEF);
        rd_chk(8'h10, 32'hDEADBEEF);

        // Streaming writes then back-to-back reads.
        for (int i = 0; i < 8; i++) acc(1'b1, 8'(i), 32'(i) * 32'h11111111);
        sa = rva;
        sb = rvb;
        for (int i = 0; i < 8; i++) acc(1'b0, 8'(i), 32'h0);
        idle(6);
        chk("stream_pulses_a", rva - sa, 8);
        chk("stream_pulses_b", rvb - sb, 8);
        chk("stream_hold_a", rdata_a, 32'h77777777);
        chk("stream_hold_b", rdata_b, 32'h77777777);
        chk("stream_hold_c", rdata_c, 32'h77777777);

        // Out-of-range accesses.
        acc(1'b1, 8'hC8, 32'h12345678);
        @(negedge clk);
        cen_n = 1'b1;
        chk("oor_wr_err", err_a, 1);
        @(negedge clk);
        chk("oor_err_pulse", err_a, 0);
        rd_chk(8'hC8, 32'h0);
        rd_chk(8'h00, 32'h0);
        rd_chk(8'h07, 32'h77777777);
        rd_chk(8'hC7, 32'h0);
        rd_chk(8'h10, 32'hDEADBEEF);

        // Reset with a READ_LAT=3 read still in flight.
        acc(1'b0, 8'h07, 32'h0);
        @(negedge clk);
        cen_n = 1'b1;
        rst = 1'b1;
        sb = rvb;
        repeat (4) @(negedge clk);
        chk("midrst_no_rvalid", rvb - sb, 0);
        chk("midrst_ready", ready_b, 0);
        rst = 1'b0;
        wait_ready(1'b0, n);
        chk("resweep_cycles", n, 200);
        rd_chk(8'h10, 32'h0);

        // Access counters (rd_chk above contributed one read).
        for (int i = 0; i < 5; i++) acc(1'b1, 8'(8'h30 + i), 32'(i) + 32'h100);
        for (int i = 0; i < 6; i++) acc(1'b0, 8'(8'h30 + i), 32'h0);
        idle(5);
        chk("cnt_wr_a", wrc_a, CNT_ON ? 5 : 0);
        chk("cnt_rd_a", rdc_a, CNT_ON ? 7 : 0);
        chk("cnt_rd_c", rdc_c, CNT_ON ? 7 : 0);
        acc(1'b0, 8'h31, 32'h0);
        acc(1'b0, 8'h32, 32'h0);
        idle(5);
        chk("cnt_rd_a9", rdc_a, CNT_ON ? 9 : 0);
        chk("cnt_rd_c_sat", rdc_c, CNT_ON ? 7 : 0);
        chk("cnt_wr_c", wrc_c, CNT_ON ? 5 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
